vcve2_vec_ex_seq: RTL and testbench
===================================

Name: vcve2_vec_ex_seq

Overview:
Element-group sequencer for vector arithmetic instructions on the shared scalar/vector execution stage. It accepts one decoded vector instruction and splits it into 32-bit word operations. For each word it presents vector register read and write addresses, drives the first-cycle and request strobes of the execution stage, and waits on its valid handshake. It sits between the vector decode/issue logic and the execution stage plus the vector register file.

Parameters:
VLEN, 128, bits per vector register; must be a power of two, at least 32.
WPR, VLEN/32, 32-bit words per vector register (derived, localparam).
VL_W, $clog2(VLEN)+1, width of vl_i; covers VLMAX = VLEN for LMUL=8 and SEW=8.

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  instruction valid; accepted only in IDLE
kill_i  in  1  flush; aborts the current instruction
vl_i  in  VL_W  element count
vsew_i  in  3  element width: 000=8, 001=16, 010=32; others illegal
lmul_i  in  2  register group: 00=1, 01=2, 10=4, 11=8
vs1_i, vs2_i, vd_i  in  5 each  base vector registers
busy_o  out  1  instruction in flight
done_o  out  1  one-cycle completion pulse
error_o  out  1  one-cycle illegal-configuration pulse
rd_vreg_o  out  5  current source register offset, added to vs1/vs2 base (see Behaviour)
rd_word_o  out  $clog2(WPR)  word within register
ex_req_o  out  1  operation presented to execution stage
ex_first_cycle_o  out  1  first cycle of current word operation
ex_valid_i  in  1  execution stage result valid
vrf_we_o  out  1  result write enable
vrf_wvreg_o  out  5  destination register
vrf_wword_o  out  $clog2(WPR)  destination word
vrf_wbe_o  out  4  byte enables

Behaviour:
- Reset: synchronous on rst_i, active-high. State goes to IDLE; every output is 0; counters are cleared. rst_i mid-instruction aborts with no further writes and no done_o.
- Latched at start_i in IDLE: vl, vsew, lmul, vs1, vs2, vd.
- Derived quantities:
  - bytes = vl << vsew
  - total_words = (bytes + 3) >> 2
  - rem = bytes[1:0]
  - VLMAX = (VLEN << lmul) >> (3 + vsew)
- Legality is checked in the start cycle. The instruction is illegal if any of the following holds: vsew > 2; vl > VLMAX; vs1, vs2 or vd is not a multiple of (1 << lmul).
  - Illegal: error_o is pulsed next cycle; the block returns to IDLE; no ex_req_o and no writes.
- vl = 0 (legal): go to DONE; done_o is pulsed the next cycle; no writes.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE -> ISSUE on a legal start_i with vl > 0.
  - ISSUE: ex_req_o=1, ex_first_cycle_o=1.
    - If ex_valid_i=1, write the word; go to ISSUE for the next word, or to DONE if it was the last word.
    - Otherwise go to WAIT.
  - WAIT: ex_req_o=1, ex_first_cycle_o=0. On ex_valid_i, same write/advance rule as ISSUE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- busy_o = 1 in ISSUE, WAIT and DONE.
- Word counter g runs 0..total_words-1.
  - Register offset = g / WPR; word = g % WPR.
  - Sources: rd_vreg_o = offset. The register-file wrapper adds the offset to vs1/vs2.
  - Destination: vrf_wvreg_o = vd + offset.
- vrf_we_o = ex_req_o & ex_valid_i (combinational); vrf_wvreg_o and vrf_wword_o equal the current g mapping.
- Byte enables: vrf_wbe_o = 4'hF, except on the last word when rem != 0, where vrf_wbe_o = (1<<rem)-1. vrf_wbe_o = 0 when vrf_we_o = 0.
- Latency with single-cycle ALU ops (ex_valid_i=1 every cycle):
  - start accepted at cycle 0.
  - Writes occur in cycles 1..N.
  - done_o at cycle N+1.
  - busy_o falls at cycle N+2.
- start_i while busy_o=1 is ignored; it is not queued.
- kill_i in any non-IDLE state:
  - IDLE next cycle; no done_o.
  - A write coinciding with kill_i is suppressed (kill_i has priority over ex_valid_i).
  - kill_i and start_i together in IDLE: start_i is ignored.
- ex_valid_i while ex_req_o=0 is ignored.

Decomposition:
- vcve2_pkg additions:
  - vsew_e (VSEW_8/16/32)
  - vlmul_e (LMUL_1/2/4/8)
  - vec_seq_state_e (IDLE/ISSUE/WAIT/DONE)
- Sub-module vcve2_vec_len_calc: purely combinational. Inputs vl, vsew, lmul and the base registers; outputs total_words, rem and legal.
- The FSM and counters stay in the top module.

Test Plan:
1. VLEN=128, vsew=010, lmul=00, vl=4, vd=8, ex_valid_i=1 -> vrf_we_o in cycles 1..4, words 0..3 of vreg 8, vrf_wbe_o=F; done_o in cycle 5.
2. vsew=000, vl=6 -> 2 writes; second write vrf_wbe_o=4'b0011.
3. lmul=01, vsew=010, vl=6, vd=4 -> writes vreg4 words 0-3, then vreg5 words 0-1; rd_vreg_o steps 0 to 1.
4. ex_valid_i low 3 cycles per word, vl=2 sew32 -> ex_first_cycle_o high only in the first cycle of each word; exactly 2 writes; done_o at cycle 9.
5. vl=0 -> done_o at cycle 1, no writes. vl=5 with sew32/lmul1 -> error_o, no writes. vd=3 with lmul=01 -> error_o. vsew=011 -> error_o.
6. kill_i, or rst_i, asserted in the same cycle as ex_valid_i at word 1 of 4 -> no write that cycle; IDLE next cycle; no done_o; busy_o=0; a following start_i runs normally.

Source files
------------

// File: rtl/vcve2_pkg.sv
// Shared types for the vcve2 vector execution path.
package vcve2_pkg;

    typedef enum logic [2:0] {
        VSEW_8  = 3'b000,
        VSEW_16 = 3'b001,
        VSEW_32 = 3'b010
    } vsew_e;

    typedef enum logic [1:0] {
        LMUL_1 = 2'b00,
        LMUL_2 = 2'b01,
        LMUL_4 = 2'b10,
        LMUL_8 = 2'b11
    } vlmul_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } vec_seq_state_e;

endpackage

// File: rtl/vcve2_vec_len_calc.sv
// Combinational length/legality decode for one vector instruction:
// number of 32-bit words touched, trailing byte count and configuration legality.
module vcve2_vec_len_calc import vcve2_pkg::*; #(
    parameter int VLEN = 128,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic [VL_W-1:0] vl_i,
    input  logic [2:0]      vsew_i,
    input  logic [1:0]      lmul_i,
    input  logic [4:0]      vs1_i,
    input  logic [4:0]      vs2_i,
    input  logic [4:0]      vd_i,
    output logic [VL_W-1:0] total_words_o,
    output logic [1:0]      rem_o,
    output logic            legal_o
);

    logic [VL_W+1:0] bytes;
    logic [31:0]     vlmax;
    logic [4:0]      align_mask;
    logic            sew_ok;
    logic            vl_ok;
    logic            align_ok;

    always_comb begin
        bytes         = {2'b00, vl_i} << vsew_i[1:0];
        total_words_o = VL_W'((32'(bytes) + 32'd3) >> 2);
        rem_o         = bytes[1:0];

        // VLMAX is only meaningful for legal element widths; sew_ok masks the rest.
        vlmax      = (32'(VLEN) << lmul_i) >> (32'd3 + 32'(vsew_i[1:0]));
        align_mask = (5'd1 << lmul_i) - 5'd1;

        sew_ok   = (vsew_i <= VSEW_32);
        vl_ok    = (32'(vl_i) <= vlmax);
        align_ok = ((vs1_i & align_mask) == 5'd0) &&
                   ((vs2_i & align_mask) == 5'd0) &&
                   ((vd_i  & align_mask) == 5'd0);
        legal_o  = sew_ok && vl_ok && align_ok;
    end

endmodule

// File: rtl/vcve2_vec_ex_seq.sv
// Element-group sequencer: walks a vector instruction one 32-bit word at a time,
// handshaking with the execution stage and generating vector register file writes.
module vcve2_vec_ex_seq import vcve2_pkg::*; #(
    parameter int VLEN = 128,
    parameter int VL_W = $clog2(VLEN) + 1,
    localparam int WPR = VLEN / 32,
    localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [VL_W-1:0] vl_i,
    input  logic [2:0]      vsew_i,
    input  logic [1:0]      lmul_i,
    input  logic [4:0]      vs1_i,
    input  logic [4:0]      vs2_i,
    input  logic [4:0]      vd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [4:0]      rd_vreg_o,
    output logic [WW-1:0]   rd_word_o,
    output logic            ex_req_o,
    output logic            ex_first_cycle_o,
    input  logic            ex_valid_i,
    output logic            vrf_we_o,
    output logic [4:0]      vrf_wvreg_o,
    output logic [WW-1:0]   vrf_wword_o,
    output logic [3:0]      vrf_wbe_o
);

    vec_seq_state_e  state_q, state_d;
    logic [VL_W-1:0] g_q, g_d;
    logic [VL_W-1:0] total_q, total_d;
    logic [1:0]      rem_q, rem_d;
    logic [4:0]      vd_q, vd_d;
    logic            error_q, error_d;

    logic [VL_W-1:0] calc_total;
    logic [1:0]      calc_rem;
    logic            calc_legal;
    logic            last_word;
    logic            advance;

    vcve2_vec_len_calc #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_len_calc (
        .vl_i          (vl_i),
        .vsew_i        (vsew_i),
        .lmul_i        (lmul_i),
        .vs1_i         (vs1_i),
        .vs2_i         (vs2_i),
        .vd_i          (vd_i),
        .total_words_o (calc_total),
        .rem_o         (calc_rem),
        .legal_o       (calc_legal)
    );

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        total_d   = total_q;
        rem_d     = rem_q;
        vd_d      = vd_q;
        error_d   = 1'b0;
        last_word = (g_q == total_q - VL_W'(1));
        advance   = ex_valid_i && !kill_i;

        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    if (!calc_legal) begin
                        error_d = 1'b1;
                    end else begin
                        total_d = calc_total;
                        rem_d   = calc_rem;
                        vd_d    = vd_i;
                        g_d     = '0;
                        state_d = (vl_i == '0) ? DONE : ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (kill_i) begin
                    state_d = IDLE;
                    g_d     = '0;
                end else if (advance) begin
                    if (last_word) begin
                        state_d = DONE;
                        g_d     = '0;
                    end else begin
                        state_d = ISSUE;
                        g_d     = g_q + VL_W'(1);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            total_q <= '0;
            rem_q   <= '0;
            vd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            total_q <= total_d;
            rem_q   <= rem_d;
            vd_q    <= vd_d;
            error_q <= error_d;
        end
    end

    // Kill and reset both squash the write and completion of the current cycle.
    always_comb begin
        ex_req_o         = (state_q == ISSUE) || (state_q == WAIT);
        ex_first_cycle_o = (state_q == ISSUE);
        busy_o           = (state_q != IDLE);
        done_o           = (state_q == DONE) && !kill_i && !rst_i;
        error_o          = error_q;
        rd_vreg_o        = 5'(g_q / VL_W'(WPR));
        rd_word_o        = WW'(g_q % VL_W'(WPR));
        vrf_we_o         = ex_req_o && ex_valid_i && !kill_i && !rst_i;
        vrf_wvreg_o      = vd_q + rd_vreg_o;
        vrf_wword_o      = rd_word_o;
        vrf_wbe_o        = 4'h0;
        if (vrf_we_o) begin
            vrf_wbe_o = (last_word && rem_q != 2'd0) ? ((4'd1 << rem_q) - 4'd1) : 4'hF;
        end
    end

endmodule

// File: tb/tb_vcve2_vec_ex_seq.sv
// Randomized self-checking bench for vcve2_vec_ex_seq against a word-list reference model.
module tb_vcve2_vec_ex_seq;

    localparam int VLEN = 128;
    localparam int VL_W = $clog2(VLEN) + 1;
    localparam int WPR  = VLEN / 32;
    localparam int WW   = $clog2(WPR);

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic            kill_i;
    logic [VL_W-1:0] vl_i;
    logic [2:0]      vsew_i;
    logic [1:0]      lmul_i;
    logic [4:0]      vs1_i;
    logic [4:0]      vs2_i;
    logic [4:0]      vd_i;
    logic            busy_o;
    logic            done_o;
    logic            error_o;
    logic [4:0]      rd_vreg_o;
    logic [WW-1:0]   rd_word_o;
    logic            ex_req_o;
    logic            ex_first_cycle_o;
    logic            ex_valid_i;
    logic            vrf_we_o;
    logic [4:0]      vrf_wvreg_o;
    logic [WW-1:0]   vrf_wword_o;
    logic [3:0]      vrf_wbe_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    vcve2_vec_ex_seq #(.VLEN(VLEN)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .kill_i           (kill_i),
        .vl_i             (vl_i),
        .vsew_i           (vsew_i),
        .lmul_i           (lmul_i),
        .vs1_i            (vs1_i),
        .vs2_i            (vs2_i),
        .vd_i             (vd_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .rd_vreg_o        (rd_vreg_o),
        .rd_word_o        (rd_word_o),
        .ex_req_o         (ex_req_o),
        .ex_first_cycle_o (ex_first_cycle_o),
        .ex_valid_i       (ex_valid_i),
        .vrf_we_o         (vrf_we_o),
        .vrf_wvreg_o      (vrf_wvreg_o),
        .vrf_wword_o      (vrf_wword_o),
        .vrf_wbe_o        (vrf_wbe_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction; abort_word >= 0 aborts (kill or reset) on that word's write cycle.
    task automatic applyStimulus(input int vl, input int vsew, input int lmul,
                                 input int vs1, input int vs2, input int vd,
                                 input int stall_min, input int stall_max,
                                 input int abort_word, input bit abort_rst);
        int  vlmax, bytes, nwords, rem, stall, mask;
        bit  legal, aborting;
        vlmax  = (vsew <= 2) ? ((VLEN << lmul) >> (3 + vsew)) : 0;
        mask   = (1 << lmul) - 1;
        legal  = (vsew <= 2) && (vl <= vlmax) &&
                 ((vs1 & mask) == 0) && ((vs2 & mask) == 0) && ((vd & mask) == 0);
        bytes  = vl * (1 << (vsew & 3));
        nwords = (bytes + 3) / 4;
        rem    = bytes % 4;

        @(negedge clk_i);
        start_i    = 1'b1;
        kill_i     = 1'b0;
        vl_i       = VL_W'(vl);
        vsew_i     = 3'(vsew);
        lmul_i     = 2'(lmul);
        vs1_i      = 5'(vs1);
        vs2_i      = 5'(vs2);
        vd_i       = 5'(vd);
        ex_valid_i = 1'($urandom_range(0, 1));
        #1;
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_we", vrf_we_o, 0);

        @(negedge clk_i);
        start_i    = 1'b0;
        ex_valid_i = 1'b0;
        if (!legal) begin
            #1;
            checkOutput("err_pulse", error_o, 1);
            checkOutput("err_busy", busy_o, 0);
            checkOutput("err_req", ex_req_o, 0);
            @(negedge clk_i);
            #1;
            checkOutput("err_low", error_o, 0);
            checkOutput("err_we", vrf_we_o, 0);
            return;
        end

        for (int g = 0; g < nwords; g++) begin
            stall = $urandom_range(stall_min, stall_max);
            for (int c = 0; c <= stall; c++) begin
                aborting   = (g == abort_word) && (c == stall);
                ex_valid_i = (c == stall);
                start_i    = 1'($urandom_range(0, 1));
                vd_i       = 5'($urandom);
                if (aborting) begin
                    if (abort_rst) rst_i = 1'b1;
                    else           kill_i = 1'b1;
                end
                #1;
                checkOutput("busy", busy_o, 1);
                checkOutput("ex_req", ex_req_o, 1);
                checkOutput("first_cycle", ex_first_cycle_o, (c == 0));
                checkOutput("done_early", done_o, 0);
                checkOutput("rd_vreg", rd_vreg_o, g / WPR);
                checkOutput("rd_word", rd_word_o, g % WPR);
                if (aborting) begin
                    checkOutput("abort_we", vrf_we_o, 0);
                end else begin
                    checkOutput("we", vrf_we_o, (c == stall));
                    if (c == stall) begin
                        checkOutput("wvreg", vrf_wvreg_o, (vd + g / WPR) % 32);
                        checkOutput("wword", vrf_wword_o, g % WPR);
                        checkOutput("wbe", vrf_wbe_o,
                                    (g == nwords - 1 && rem != 0) ? ((1 << rem) - 1) : 15);
                    end else begin
                        checkOutput("wbe_idle", vrf_wbe_o, 0);
                    end
                end
                @(negedge clk_i);
                if (aborting) begin
                    rst_i      = 1'b0;
                    kill_i     = 1'b0;
                    start_i    = 1'b0;
                    ex_valid_i = 1'b0;
                    #1;
                    checkOutput("abort_busy", busy_o, 0);
                    checkOutput("abort_done", done_o, 0);
                    checkOutput("abort_req", ex_req_o, 0);
                    return;
                end
            end
        end

        start_i    = 1'b0;
        ex_valid_i = 1'($urandom_range(0, 1));
        #1;
        checkOutput("done_pulse", done_o, 1);
        checkOutput("done_busy", busy_o, 1);
        checkOutput("done_req", ex_req_o, 0);
        checkOutput("done_we", vrf_we_o, 0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        #1;
        checkOutput("post_done", done_o, 0);
        checkOutput("post_busy", busy_o, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vsew, lmul, vlmax, vl, mask, vs1, vs2, vd, abort;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        kill_i     = 1'b0;
        vl_i       = '0;
        vsew_i     = '0;
        lmul_i     = '0;
        vs1_i      = '0;
        vs2_i      = '0;
        vd_i       = '0;
        ex_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_error", error_o, 0);
        checkOutput("rst_req", ex_req_o, 0);
        checkOutput("rst_we", vrf_we_o, 0);
        checkOutput("rst_rd_vreg", rd_vreg_o, 0);
        rst_i = 1'b0;

        applyStimulus(4, 2, 0, 0, 0, 8, 0, 0, -1, 0);
        applyStimulus(6, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        applyStimulus(6, 2, 1, 0, 2, 4, 0, 0, -1, 0);
        applyStimulus(2, 2, 0, 0, 0, 0, 3, 3, -1, 0);
        applyStimulus(0, 2, 0, 0, 0, 0, 0, 0, -1, 0);
        applyStimulus(5, 2, 0, 0, 0, 0, 0, 0, -1, 0);
        applyStimulus(4, 2, 1, 0, 0, 3, 0, 0, -1, 0);
        applyStimulus(4, 3, 0, 0, 0, 0, 0, 0, -1, 0);
        applyStimulus(4, 2, 0, 0, 0, 8, 0, 1, 1, 0);
        applyStimulus(4, 2, 0, 0, 0, 8, 0, 0, -1, 0);
        applyStimulus(4, 2, 0, 0, 0, 8, 0, 1, 1, 1);
        applyStimulus(4, 2, 0, 0, 0, 8, 0, 0, -1, 0);
        applyStimulus(128, 0, 3, 8, 16, 24, 0, 0, -1, 0);

        // Kill together with start in IDLE must not launch anything.
        @(negedge clk_i);
        start_i = 1'b1;
        kill_i  = 1'b1;
        vl_i    = VL_W'(4);
        vsew_i  = 3'd2;
        lmul_i  = 2'd0;
        vd_i    = 5'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        kill_i  = 1'b0;
        #1;
        checkOutput("kill_start_busy", busy_o, 0);
        checkOutput("kill_start_err", error_o, 0);

        for (int n = 0; n < 60; n++) begin
            vsew  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            lmul  = $urandom_range(0, 3);
            vlmax = (vsew <= 2) ? ((VLEN << lmul) >> (3 + vsew)) : 16;
            vl    = $urandom_range(0, vlmax + 2);
            if (vl > 255) vl = 255;
            mask  = (1 << lmul) - 1;
            vs1   = $urandom_range(0, 31);
            vs2   = $urandom_range(0, 31);
            vd    = $urandom_range(0, 31);
            if ($urandom_range(0, 7) != 0) begin
                vs1 = vs1 & ~mask;
                vs2 = vs2 & ~mask;
                vd  = vd & ~mask;
            end
            abort = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            applyStimulus(vl, vsew, lmul, vs1, vs2, vd, 0, 2, abort, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
